// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package serial_adder_pkg;

  // Encoding is fixed; the unused code 2'd3 is treated as illegal and recovers to idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit counter width: enough to count 0..w-1, never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder built from two half-adder cells and an OR for the carry.
// Latency: combinational.
// Backpressure: none.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (.a(a),  .b(b),   .s(s1), .c(c1));
  half_adder u_ha1 (.a(s1), .b(cin), .s(s),  .c(c2));

  // Both half-adder carries can never be high together, so OR suffices.
  assign cout = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// Half adder cell: s = a ^ b, c = a & b.
// Latency: combinational.
// Backpressure: none.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: loads a, b, cin on start, adds LSB-first one bit per clock.
// Latency: done is high in the cycle after the WIDTH-th edge following acceptance.
// Backpressure: start is only sampled in idle; requests while busy/done are dropped.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q,  op_a_d;
  logic [WIDTH-1:0] op_b_q,  op_b_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q,  cout_d;

  logic             fa_s;
  logic             fa_c;
  logic             last_bit;
  logic [WIDTH-1:0] acc_shift;

  full_adder u_fa (
    .a    (op_a_q[0]),
    .b    (op_b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign last_bit  = (cnt_q == CW'(WIDTH - 1));
  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lines up with the LSB.
  assign acc_shift = (acc_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  // Next-state and datapath update: load in idle, shift one bit per clock in run.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_a_d  = a;
          op_b_d  = b;
          carry_d = cin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        op_a_d  = op_a_q >> 1;
        op_b_d  = op_b_q >> 1;
        carry_d = fa_c;
        acc_d   = acc_shift;
        if (last_bit) begin
          sum_d   = acc_shift;
          cout_d  = fa_c;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything including results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  // Status decoded straight from the state flops, so mutually exclusive and glitch-free.
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
